// File: rtl/cfg_latch_loader_if.sv
// Serial config port plus the shared word bus / strobe lines toward the SLICEL latch column.
interface cfg_latch_loader_if #(
  parameter int MEM_SIZE   = 16,
  parameter int NUM_BLOCKS = 8
);
  logic                  start;
  logic                  cfg_valid;
  logic                  cfg_bit;
  logic                  cfg_ready;
  logic [MEM_SIZE-1:0]   config_in;
  logic [NUM_BLOCKS-1:0] comb_set;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (output start, cfg_valid, cfg_bit,
                  input  cfg_ready, config_in, comb_set, busy, done, err);
  modport slave  (input  start, cfg_valid, cfg_bit,
                  output cfg_ready, config_in, comb_set, busy, done, err);
endinterface

// File: rtl/cfg_latch_loader.sv
// Serial-to-parallel loader committing one MEM_SIZE word per latch bank with a one-hot strobe.
// Optional per-word even parity check enabled by defining CFG_PARITY_EN.
module cfg_latch_loader #(
  parameter int MEM_SIZE   = 16,
  parameter int NUM_BLOCKS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  cfg_latch_loader_if.slave bus
);
  localparam int BLK_BITS = $clog2(NUM_BLOCKS);
  localparam int CNT_BITS = $clog2(MEM_SIZE);
  localparam logic [BLK_BITS-1:0] LAST_BLK = BLK_BITS'(NUM_BLOCKS - 1);
  localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(MEM_SIZE - 1);

`ifdef CFG_PARITY_EN
  typedef enum logic [2:0] {IDLE, SHIFT, PARITY, COMMIT, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, DONE} state_t;
`endif

  state_t                state, state_n;
  logic [BLK_BITS-1:0]   blk_idx, blk_n;
  logic [CNT_BITS-1:0]   bit_cnt, cnt_n;
  logic [MEM_SIZE-1:0]   shreg, shreg_n, shifted;
  logic [MEM_SIZE-1:0]   config_q, config_n;
  logic [NUM_BLOCKS-1:0] strobe_q, strobe_n, onehot;
  logic                  ready_q, ready_n;
  logic                  busy_q, busy_n;
  logic                  done_q, done_n;
  logic                  accept;
`ifdef CFG_PARITY_EN
  logic                  err_q, err_n;
`endif

  assign accept  = bus.cfg_valid & ready_q;
  assign shifted = {shreg[MEM_SIZE-2:0], bus.cfg_bit};
  assign onehot  = NUM_BLOCKS'(1) << blk_idx;

  // Outputs are registered from next-state so the strobe lands on the edge that takes the last bit.
  always_comb begin
    state_n  = state;
    blk_n    = blk_idx;
    cnt_n    = bit_cnt;
    shreg_n  = shreg;
    config_n = config_q;
    strobe_n = '0;
`ifdef CFG_PARITY_EN
    err_n    = err_q;
`endif
    unique case (state)
      IDLE: if (bus.start) begin
        state_n = SHIFT;
        blk_n   = '0;
        cnt_n   = '0;
`ifdef CFG_PARITY_EN
        err_n   = 1'b0;
`endif
      end
      SHIFT: if (accept) begin
        shreg_n = shifted;
        cnt_n   = bit_cnt + 1'b1;
        if (bit_cnt == LAST_BIT) begin
`ifdef CFG_PARITY_EN
          state_n = PARITY;
`else
          state_n  = COMMIT;
          config_n = shifted;
          strobe_n = onehot;
`endif
        end
      end
`ifdef CFG_PARITY_EN
      PARITY: if (accept) begin
        if (^{shreg, bus.cfg_bit} == 1'b0) begin
          state_n  = COMMIT;
          config_n = shreg;
          strobe_n = onehot;
        end else begin
          // Bad word: skip its strobe and abort the whole load.
          state_n = DONE;
          err_n   = 1'b1;
        end
      end
`endif
      COMMIT: begin
        if (blk_idx == LAST_BLK) begin
          state_n = DONE;
        end else begin
          state_n = SHIFT;
          blk_n   = blk_idx + 1'b1;
          cnt_n   = '0;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifdef CFG_PARITY_EN
    ready_n = (state_n == SHIFT) || (state_n == PARITY);
`else
    ready_n = (state_n == SHIFT);
`endif
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      blk_idx  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      config_q <= '0;
      strobe_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef CFG_PARITY_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      blk_idx  <= blk_n;
      bit_cnt  <= cnt_n;
      shreg    <= shreg_n;
      config_q <= config_n;
      strobe_q <= strobe_n;
      ready_q  <= ready_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
`ifdef CFG_PARITY_EN
      err_q    <= err_n;
`endif
    end
  end

  assign bus.cfg_ready = ready_q;
  assign bus.config_in = config_q;
  assign bus.comb_set  = strobe_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef CFG_PARITY_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_latch_loader.sv
// Directed bench for cfg_latch_loader: scoreboarded bank commits, timing, stalls, reset and parity.
module tb_cfg_latch_loader;
  localparam int MEM_SIZE   = 16;
  localparam int NUM_BLOCKS = 8;
`ifdef CFG_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int LOAD_CYC = NUM_BLOCKS * (MEM_SIZE + 1 + PAR) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cfg_latch_loader_if #(.MEM_SIZE(MEM_SIZE), .NUM_BLOCKS(NUM_BLOCKS)) bus ();
  cfg_latch_loader #(.MEM_SIZE(MEM_SIZE), .NUM_BLOCKS(NUM_BLOCKS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct { int blk; logic [MEM_SIZE-1:0] word; } exp_t;
  exp_t sb[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, strobe_cnt = 0, exp_blk = 0;
  logic                prev_strobe = 1'b0;
  logic [MEM_SIZE-1:0] prev_word = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Commit monitor: pops the scoreboard on every strobe and checks the word holds afterwards.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (prev_strobe) begin
        check("cfg_hold", bus.config_in, prev_word);
        check("strobe_1cyc", bus.comb_set, 0);
      end
      if (bus.comb_set != '0) begin
        strobe_cnt++;
        check("onehot", $onehot(bus.comb_set), 1);
        if (sb.size() == 0) begin
          check("unexpected_strobe", bus.comb_set, 0);
        end else begin
          e = sb.pop_front();
          check("strobe_bank", bus.comb_set, 32'(1) << e.blk);
          check("word", bus.config_in, e.word);
        end
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    prev_strobe = rst_n && (bus.comb_set != '0);
    prev_word   = bus.config_in;
  end

  task automatic send_bit(input logic b, input bit gaps, input bit noise);
    for (int guard = 0; guard < 200; guard++) begin
      @(negedge clk);
      bus.start = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      if (gaps && $urandom_range(1, 0) == 0) begin
        bus.cfg_valid = 1'b0;
        bus.cfg_bit   = 1'($urandom_range(1, 0));
      end else if (bus.cfg_ready) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_bit   = b;
        @(posedge clk);
        return;
      end else begin
        bus.cfg_valid = 1'b1;
        bus.cfg_bit   = noise ? ~b : b;
      end
    end
    check("bit_timeout", 0, 1);
  endtask

  task automatic send_word(input logic [MEM_SIZE-1:0] w, input logic p, input bit gaps, input bit noise);
    if (PAR == 0 || (^w ^ p) == 1'b0) sb.push_back('{exp_blk, w});
    exp_blk++;
    for (int i = MEM_SIZE - 1; i >= 0; i--) send_bit(w[i], gaps, noise);
    if (PAR != 0) send_bit(p, gaps, noise);
  endtask

  task automatic start_load(output int c0);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.cfg_valid = 1'b0;
    c0      = cyc;
    exp_blk = 0;
  endtask

  task automatic end_load(input string tag, input int d0);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.cfg_valid = 1'b0;
    for (int i = 0; i < 400 && done_cnt == d0; i++) begin
      @(negedge clk);
      #1;
    end
    check(tag, done_cnt, d0 + 1);
  endtask

  initial begin
    logic [MEM_SIZE-1:0] words [NUM_BLOCKS];
    logic [MEM_SIZE-1:0] w;
    int c0, d0, s0;
    words = '{16'h0001, 16'h8000, 16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h0000, 16'h1234, 16'hBEEF};
    bus.start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_bit = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready", bus.cfg_ready, 0);
    check("rst_config", bus.config_in, 0);
    check("rst_comb_set", bus.comb_set, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    rst_n = 1'b1;

    // Back-to-back load of the reference words, with end-to-end timing.
    d0 = done_cnt; s0 = strobe_cnt;
    start_load(c0);
    for (int b = 0; b < NUM_BLOCKS; b++) send_word(words[b], ^words[b], 1'b0, 1'b0);
    end_load("load_a_done", d0);
    check("load_a_cycles", done_cyc, c0 + LOAD_CYC);
    check("load_a_strobes", strobe_cnt - s0, NUM_BLOCKS);
    check("load_a_err", bus.err, 0);
    @(negedge clk);
    check("load_a_idle_busy", bus.busy, 0);
    check("load_a_sb_empty", sb.size(), 0);

    // Random words with 50% valid gaps.
    d0 = done_cnt;
    start_load(c0);
    for (int b = 0; b < NUM_BLOCKS; b++) begin
      w = MEM_SIZE'($urandom);
      send_word(w, ^w, 1'b1, 1'b0);
    end
    end_load("load_b_done", d0);
    check("load_b_sb_empty", sb.size(), 0);

    // start pulses mid-load and bit toggling while not ready.
    d0 = done_cnt; s0 = strobe_cnt;
    start_load(c0);
    for (int b = 0; b < NUM_BLOCKS; b++) begin
      w = MEM_SIZE'($urandom);
      send_word(w, ^w, 1'b0, 1'b1);
    end
    end_load("load_c_done", d0);
    check("load_c_strobes", strobe_cnt - s0, NUM_BLOCKS);
    check("load_c_sb_empty", sb.size(), 0);

    // Reset during the shift of bank 3.
    start_load(c0);
    for (int b = 0; b < 3; b++) send_word(words[b], ^words[b], 1'b0, 1'b0);
    sb.push_back('{3, words[3]});
    for (int i = MEM_SIZE - 1; i >= MEM_SIZE / 2; i--) send_bit(words[3][i], 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("mid_busy", bus.busy, 1);
    check("mid_sb_pending", sb.size(), 1);
    #2 rst_n = 1'b0;
    bus.cfg_valid = 1'b0;
    #1;
    check("arst_comb_set", bus.comb_set, 0);
    check("arst_config", bus.config_in, 0);
    check("arst_ready", bus.cfg_ready, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;

    d0 = done_cnt;
    start_load(c0);
    for (int b = 0; b < NUM_BLOCKS; b++) send_word(words[NUM_BLOCKS - 1 - b], ^words[NUM_BLOCKS - 1 - b], 1'b0, 1'b0);
    end_load("reload_done", d0);
    check("reload_cycles", done_cyc, c0 + LOAD_CYC);
    check("reload_sb_empty", sb.size(), 0);

`ifdef CFG_PARITY_EN
    // Good word then a parity-failing word aborts the load.
    d0 = done_cnt; s0 = strobe_cnt;
    start_load(c0);
    send_word(16'h0003, 1'b0, 1'b0, 1'b0);
    send_word(16'h0007, 1'b0, 1'b0, 1'b0);
    end_load("par_abort_done", d0);
    check("par_strobes", strobe_cnt - s0, 1);
    check("par_err_set", bus.err, 1);
    @(negedge clk);
    check("par_idle_busy", bus.busy, 0);
    check("par_err_held", bus.err, 1);
    check("par_sb_empty", sb.size(), 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("par_err_cleared", bus.err, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
